// File: rtl/clk_div_mux.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_mux
// Description : NUM_CH programmable clock dividers with a glitch-free,
//               handshaked output select and a rising-edge enable strobe.
//               Build option CLKDIV_MUX_PHASE_RESET_EN: the target divider is
//               restarted when HOLD is entered, giving a fixed switch latency.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_mux #(
    parameter  int NUM_CH = 4,
    parameter  int DIV_W  = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [SEL_W-1:0]        sel_req,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    output logic                    sel_err,
    output logic [SEL_W-1:0]        sel_cur,
    output logic                    switching,
    output logic                    clk_out,
    output logic                    clk_en
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_cfg [NUM_CH];
    logic [DIV_W-1:0] r_cnt [NUM_CH];
    logic             r_phase [NUM_CH];
    logic [SEL_W-1:0] r_sel_cur;
    logic [SEL_W-1:0] r_new_sel;
    logic [SEL_W-1:0] w_sel_cur_nxt;
    logic [SEL_W-1:0] w_new_sel_nxt;
    logic             r_clk_out;
    logic             r_clk_en;
    logic             r_sel_err;
    logic [DIV_W-1:0] r_lo_run;
    logic             w_req_bad;
    logic             w_cur_ph;
    logic             w_new_ph;
    logic             w_clk_nxt;
    logic             w_err_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cfg
            assign w_cfg[gi] = div_cfg[gi*DIV_W +: DIV_W];
        end

        if (NUM_CH == (1 << SEL_W)) begin : g_req_full
            assign w_req_bad = 1'b0;
        end else begin : g_req_part
            assign w_req_bad = (sel_req >= SEL_W'(NUM_CH));
        end
    endgenerate

    assign w_cur_ph = r_phase[r_sel_cur];
    assign w_new_ph = r_phase[r_new_sel];

`ifdef CLKDIV_MUX_PHASE_RESET_EN
    logic w_hold_entry;
    assign w_hold_entry = (r_state == ST_DRAIN) && !w_cur_ph;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]   <= '0;
                r_phase[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
`ifdef CLKDIV_MUX_PHASE_RESET_EN
                if (w_hold_entry && (r_new_sel == SEL_W'(i))) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= 1'b0;
                end else
`endif
                // >= so a config lowered below the running count wraps at once
                if (r_cnt[i] >= w_cfg[i]) begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= ~r_phase[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_cur_nxt = r_sel_cur;
        w_new_sel_nxt = r_new_sel;
        w_clk_nxt     = w_cur_ph;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (sel_valid) begin
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (sel_req != r_sel_cur) begin
                        w_new_sel_nxt = sel_req;
                        w_state_nxt   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!w_cur_ph) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_clk_nxt = 1'b0;
                // the exit cycle itself is low too, so cfg_old prior lows give
                // a total low time of at least one old-channel half-period
                if (!w_new_ph && (r_lo_run >= w_cfg[r_sel_cur])) begin
                    w_sel_cur_nxt = r_new_sel;
                    w_state_nxt   = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_RUN;
            r_sel_cur <= '0;
            r_new_sel <= '0;
            r_clk_out <= 1'b0;
            r_clk_en  <= 1'b0;
            r_sel_err <= 1'b0;
            r_lo_run  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_cur <= w_sel_cur_nxt;
            r_new_sel <= w_new_sel_nxt;
            r_clk_out <= w_clk_nxt;
            r_clk_en  <= (r_state == ST_RUN) && !r_clk_out && w_cur_ph;
            r_sel_err <= w_err_nxt;
            if (w_clk_nxt) begin
                r_lo_run <= '0;
            end else if (!(&r_lo_run)) begin
                r_lo_run <= r_lo_run + 1'b1;
            end
        end
    end

    assign sel_ready = (r_state == ST_RUN);
    assign switching = (r_state != ST_RUN);
    assign sel_cur   = r_sel_cur;
    assign sel_err   = r_sel_err;
    assign clk_out   = r_clk_out;
    assign clk_en    = r_clk_en;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_mux
// Description : Self-checking bench for clk_div_mux (NUM_CH=3) against a
//               time-based divider model plus directed pulse-width checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_mux;

    localparam int NUM_CH  = 3;
    localparam int DIV_W   = 8;
    localparam int SEL_W   = 2;
    localparam int S_RUN   = 0;
    localparam int S_DRAIN = 1;
    localparam int S_HOLD  = 2;

    logic                    aclk      = 1'b0;
    logic                    aresetn   = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_cfg   = {8'd1, 8'd3, 8'd4};
    logic [SEL_W-1:0]        sel_req   = '0;
    logic                    sel_valid = 1'b0;
    logic                    sel_ready;
    logic                    sel_err;
    logic [SEL_W-1:0]        sel_cur;
    logic                    switching;
    logic                    clk_out;
    logic                    clk_en;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    int cfg [NUM_CH] = '{4, 3, 1};

    always #5 aclk = ~aclk;

    clk_div_mux #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .div_cfg   (div_cfg),
        .sel_req   (sel_req),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_err   (sel_err),
        .sel_cur   (sel_cur),
        .switching (switching),
        .clk_out   (clk_out),
        .clk_en    (clk_en)
    );

    // Model: channel phase is a pure function of edges elapsed since its restart.
    int m_k, m_state, m_sel, m_new, m_lo;
    bit m_clk, m_en, m_err;
    int base [NUM_CH];

    function automatic bit ph(input int ch);
        return bit'(((m_k - base[ch]) / (cfg[ch] + 1)) % 2);
    endfunction

    function automatic bit nclk();
        return (m_state == S_HOLD) ? 1'b0 : ph(m_sel);
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_k <= 0; m_state <= S_RUN; m_sel <= 0; m_new <= 0; m_lo <= 0;
            m_clk <= 1'b0; m_en <= 1'b0; m_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) base[i] <= 0;
        end else begin
            m_k   <= m_k + 1;
            m_clk <= nclk();
            m_lo  <= nclk() ? 0 : m_lo + 1;
            m_en  <= (m_state == S_RUN) && !m_clk && ph(m_sel);
            m_err <= (m_state == S_RUN) && sel_valid && (int'(sel_req) >= NUM_CH);
            case (m_state)
                S_RUN: if (sel_valid && int'(sel_req) < NUM_CH && int'(sel_req) != m_sel) begin
                    m_new   <= int'(sel_req);
                    m_state <= S_DRAIN;
                end
                S_DRAIN: if (!ph(m_sel)) begin
                    m_state <= S_HOLD;
`ifdef CLKDIV_MUX_PHASE_RESET_EN
                    base[m_new] <= m_k + 1;
`endif
                end
                S_HOLD: if (!ph(m_new) && m_lo >= cfg[m_sel]) begin
                    m_sel   <= m_new;
                    m_state <= S_RUN;
                end
                default: m_state <= S_RUN;
            endcase
        end
    end

    always @(negedge aclk) begin
        if (chk_on) begin
            checks++;
            if (clk_out !== m_clk || clk_en !== m_en || int'(sel_cur) != m_sel ||
                switching !== (m_state != S_RUN) || sel_ready !== (m_state == S_RUN) ||
                sel_err !== m_err) begin
                failures++;
                $display("FAIL model_cmp t=%0t got clk_out=%b clk_en=%b sel_cur=%0d switching=%b sel_ready=%b sel_err=%b required %b %b %0d %b %b %b",
                         $time, clk_out, clk_en, sel_cur, switching, sel_ready, sel_err,
                         m_clk, m_en, m_sel, (m_state != S_RUN), (m_state == S_RUN), m_err);
            end
        end
    end

    // Width of the most recently completed high and low runs of clk_out.
    int  last_hi = 0, last_lo = 0, mon_run = 0;
    bit  mon_prev = 1'b0;
    always @(negedge aclk) begin
        if (chk_on) begin
            if (clk_out == mon_prev) begin
                mon_run <= mon_run + 1;
            end else begin
                if (mon_prev) last_hi <= mon_run;
                else          last_lo <= mon_run;
                mon_run <= 1;
            end
            mon_prev <= clk_out;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        checks++;
        if (act < lim) begin
            failures++;
            $display("FAIL %s: got %0d required >= %0d", name, act, lim);
        end
    endtask

    task automatic wait_level(input logic v, input string name);
        int n = 0;
        @(negedge aclk);
        while (clk_out !== v && n < 200) begin
            @(negedge aclk);
            n++;
        end
        #1;
        check(name, int'(clk_out), int'(v));
    endtask

    task automatic wait_hold_entry(input string name);
        int n = 0;
        @(negedge aclk);
        while (!(switching && !clk_out) && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check(name, int'(switching && !clk_out), 1);
    endtask

    task automatic do_req(input int ch);
        @(posedge aclk); #2;
        sel_req   = SEL_W'(ch);
        sel_valid = 1'b1;
        @(posedge aclk); #2;
        sel_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk); #2;
        aresetn = 1'b0;
        repeat (5) @(posedge aclk);
        @(negedge aclk); #2;
        aresetn = 1'b1;
    endtask

    initial begin
        int n;
        // reset state
        repeat (5) @(posedge aclk);
        #1;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_clk_en", int'(clk_en), 0);
        check("rst_sel_cur", int'(sel_cur), 0);
        check("rst_switching", int'(switching), 0);
        chk_on = 1'b1;
        @(negedge aclk); #2;
        aresetn = 1'b1;
        #1;
        check("rel_sel_ready", int'(sel_ready), 1);

        // channel 0 at cfg 4: 5 high / 5 low, one clk_en per period
        wait_level(1'b0, "c0_low");
        wait_level(1'b1, "c0_rise");
        wait_level(1'b0, "c0_fall");
        check("c0_high_w", last_hi, 5);
        wait_level(1'b1, "c0_rise2");
        check("c0_low_w", last_lo, 5);
        n = 0;
        repeat (20) begin
            @(negedge aclk);
            n += int'(clk_en);
        end
        check("c0_en_count", n, 2);

        // reset asserted while holding for channel 1
        wait_level(1'b0, "r5_low");
        wait_level(1'b1, "r5_rise");
        do_req(1);
        check("r5_ready_low", int'(sel_ready), 0);
        wait_hold_entry("r5_hold");
        #1 aresetn = 1'b0;
        #1;
        check("r5_sel_cur", int'(sel_cur), 0);
        check("r5_clk_out", int'(clk_out), 0);
        check("r5_switching", int'(switching), 0);
        repeat (3) @(posedge aclk);
        @(negedge aclk); #2;
        aresetn = 1'b1;
        wait_level(1'b1, "r5_resume_rise");
        wait_level(1'b0, "r5_resume_fall");
        check("r5_resume_high_w", last_hi, 5);

        // switch 0 -> 1: latency from HOLD entry to first rise
        wait_level(1'b0, "s1_low");
        wait_level(1'b1, "s1_rise");
        do_req(1);
        wait_hold_entry("s1_hold");
        n = 0;
        while (clk_out !== 1'b1 && n < 200) begin
            @(negedge aclk);
            n++;
        end
`ifdef CLKDIV_MUX_PHASE_RESET_EN
        check("s1_rise_latency", n, 5);
`else
        check_ge("s1_rise_latency", n, 5);
`endif
        #1;
        check("s1_sel_cur", int'(sel_cur), 1);
        wait_level(1'b0, "s1_fall");
        check("s1_high_w", last_hi, 4);
        check_ge("s1_low_w", last_lo, 5);

        // switch 0 -> 2 requested while clk_out high
        do_reset();
        wait_level(1'b0, "s2_low");
        wait_level(1'b1, "s2_rise");
        do_req(2);
        check("s2_ready_low", int'(sel_ready), 0);
        check("s2_switching", int'(switching), 1);
        wait_level(1'b0, "s2_fall");
        check("s2_old_high_w", last_hi, 5);
        wait_level(1'b1, "s2_new_rise");
        check_ge("s2_gap_low_w", last_lo, 5);
        check("s2_sel_cur", int'(sel_cur), 2);
        wait_level(1'b0, "s2_new_fall");
        check("s2_new_high_w", last_hi, 2);
        wait_level(1'b1, "s2_new_rise2");
        check("s2_new_low_w", last_lo, 2);

        // out-of-range request, then request for the current channel
        do_req(3);
        check("e_sel_err", int'(sel_err), 1);
        check("e_sel_cur", int'(sel_cur), 2);
        @(posedge aclk); #2;
        check("e_sel_err_clear", int'(sel_err), 0);
        check("e_switching", int'(switching), 0);
        do_req(2);
        check("same_switching", int'(switching), 0);
        check("same_ready", int'(sel_ready), 1);
        wait_level(1'b0, "same_low");
        wait_level(1'b1, "same_rise");
        wait_level(1'b0, "same_fall");
        check("same_high_w", last_hi, 2);
        check("same_low_w", last_lo, 2);

        @(negedge aclk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
